// File: rtl/spi_ctrl_engine.sv
// SPI transaction controller: host control register, frame buffer, burst sequencer
// and a CPOL/CPHA-configurable shift engine that writes received frames back in place.
module spi_ctrl_engine #(
    parameter int N    = 5,
    parameter int DW   = 8,
    parameter int CS_N = 4,
    parameter int DIV  = 4,
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_i,
    input  logic            reg_sel_i,
    input  logic [N-1:0]    addr_i,
    input  logic [31:0]     entrada_i,
    output logic [31:0]     salida_o,
    output logic            spi_sclk_o,
    output logic            spi_mosi_o,
    input  logic            spi_miso_i,
    output logic [CS_N-1:0] spi_cs_n_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

    state_t state, state_next;

    logic [DW-1:0]   mem [2**N];

    logic            send;
    logic            cs_ctrl;
    logic            all_1s;
    logic            all_0s;
    logic [3:0]      cs_sel;
    logic [N-1:0]    n_tx_end;
    logic [N:0]      n_rx;
    logic [N-1:0]    idx;

    logic [DW-1:0]   tx_shift;
    logic [DW-1:0]   rx_shift;
    logic [15:0]     div_cnt;
    logic [5:0]      bit_cnt;
    logic            phase;

    logic            ctrl_wr;
    logic            buf_wr;
    logic            start;
    logic            half_done;
    logic            last_edge;
    logic [3:0]      cs_sel_eff;
    logic [CS_N-1:0] cs_dec;
    logic [DW-1:0]   load_word;
    logic [31:0]     status_word;
    logic            unused_bits;

    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign ctrl_wr   = wr_i && !reg_sel_i && !busy_o;
    assign buf_wr    = wr_i && reg_sel_i && !busy_o;
    // A send in the same write that launches the burst must start it immediately
    assign start     = (state == IDLE) && (send || (ctrl_wr && entrada_i[0]));
    assign half_done = (div_cnt == 16'(DIV - 1));
    assign last_edge = half_done && phase && (bit_cnt == 6'(DW - 1));
    assign cs_sel_eff = ctrl_wr ? entrada_i[7:4] : cs_sel;
    assign unused_bits = ^entrada_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_edge) state_next = STORE;
            STORE:   state_next = (idx == n_tx_end) ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Out-of-range selects leave every line deasserted but the burst still runs
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < CS_N; i++) begin
            cs_dec[i] = (int'(cs_sel_eff) != i);
        end
    end

    always_comb begin
        load_word = mem[idx];
        if (all_0s) load_word = '0;
        if (all_1s) load_word = '1;
    end

    always_comb begin
        status_word            = '0;
        status_word[0]         = send;
        status_word[1]         = cs_ctrl;
        status_word[2]         = all_1s;
        status_word[3]         = all_0s;
        status_word[7:4]       = cs_sel;
        status_word[8 +: N]    = n_tx_end;
        status_word[16 +: N+1] = n_rx;
        status_word[31]        = busy_o;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            send       <= 1'b0;
            cs_ctrl    <= 1'b0;
            all_1s     <= 1'b0;
            all_0s     <= 1'b0;
            cs_sel     <= '0;
            n_tx_end   <= '0;
            n_rx       <= '0;
            idx        <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            spi_sclk_o <= 1'(CPOL);
            spi_mosi_o <= 1'b0;
            spi_cs_n_o <= '1;
            salida_o   <= '0;
        end else begin
            salida_o <= reg_sel_i ? 32'(mem[addr_i]) : status_word;

            // Clearing cs_ctrl releases a chip select held over from a previous burst
            if (ctrl_wr) begin
                send     <= entrada_i[0];
                cs_ctrl  <= entrada_i[1];
                all_1s   <= entrada_i[2];
                all_0s   <= entrada_i[3];
                cs_sel   <= entrada_i[7:4];
                n_tx_end <= entrada_i[8 +: N];
                if (!entrada_i[1]) spi_cs_n_o <= '1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        n_rx       <= '0;
                        idx        <= '0;
                        spi_cs_n_o <= cs_dec;
                    end
                end
                LOAD: begin
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    phase      <= 1'b0;
                    rx_shift   <= '0;
                    spi_sclk_o <= 1'(CPOL);
                    if (CPHA == 0) begin
                        spi_mosi_o <= load_word[DW-1];
                        tx_shift   <= load_word << 1;
                    end else begin
                        tx_shift   <= load_word;
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        div_cnt    <= '0;
                        spi_sclk_o <= ~spi_sclk_o;
                        phase      <= ~phase;
                        // Leading edge samples in mode CPHA=0, drives in CPHA=1; trailing is the reverse
                        if (phase == (CPHA != 0)) begin
                            rx_shift <= (rx_shift << 1) | DW'(spi_miso_i);
                        end else begin
                            spi_mosi_o <= tx_shift[DW-1];
                            tx_shift   <= tx_shift << 1;
                        end
                        if (phase) bit_cnt <= bit_cnt + 6'd1;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                STORE: begin
                    n_rx <= n_rx + 1'b1;
                    if (idx != n_tx_end) idx <= idx + 1'b1;
                end
                DONE: begin
                    send <= 1'b0;
                    if (!cs_ctrl) spi_cs_n_o <= '1;
                end
                default: ;
            endcase
        end
    end

    // Buffer contents survive reset; received frames overwrite the transmitted slot
    always_ff @(posedge clk) begin
        if (state == STORE) begin
            mem[idx] <= rx_shift;
        end else if (buf_wr) begin
            mem[addr_i] <= entrada_i[DW-1:0];
        end
    end

endmodule

// File: tb/tb_spi_ctrl_engine.sv
// Scoreboard bench for spi_ctrl_engine: stimulus queues expected reads, SPI bits
// and burst lengths; independent monitors pop and compare as the DUT responds.
module tb_spi_ctrl_engine;

    localparam int N    = 5;
    localparam int DW   = 8;
    localparam int CS_N = 4;
    localparam int DIV  = 2;
    localparam int FRAME_CYC = 2 * DIV * DW + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr;
    logic            reg_sel;
    logic [N-1:0]    addr;
    logic [31:0]     din;
    logic [31:0]     salida;
    logic            spi_sclk;
    logic            spi_mosi;
    logic            spi_miso;
    logic [CS_N-1:0] spi_cs_n;
    logic            busy;
    logic            done;
    logic            loop_miso = 1'b0;

    typedef struct {logic [31:0] val; string name;} rd_exp_t;
    typedef struct {logic mosi; logic [CS_N-1:0] cs;} bit_exp_t;
    typedef struct {int len; logic [CS_N-1:0] cs;} burst_exp_t;

    rd_exp_t    rd_q[$];
    bit_exp_t   spi_q[$];
    burst_exp_t burst_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign spi_miso = loop_miso ? spi_mosi : 1'b0;

    spi_ctrl_engine #(.N(N), .DW(DW), .CS_N(CS_N), .DIV(DIV), .CPOL(0), .CPHA(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_i       (wr),
        .reg_sel_i  (reg_sel),
        .addr_i     (addr),
        .entrada_i  (din),
        .salida_o   (salida),
        .spi_sclk_o (spi_sclk),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso),
        .spi_cs_n_o (spi_cs_n),
        .busy_o     (busy),
        .done_o     (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not expected by scoreboard", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sel, input logic [N-1:0] a, input logic [31:0] d);
        wr      = 1'b1;
        reg_sel = sel;
        addr    = a;
        din     = d;
        tick();
        wr      = 1'b0;
    endtask

    function automatic logic [31:0] ctrlWord(input logic snd, input logic csc, input logic a1,
                                             input logic a0, input logic [3:0] sel, input logic [4:0] ntx);
        return {19'b0, ntx, sel, a0, a1, csc, snd};
    endfunction

    // ---------------- read scoreboard ----------------
    logic rd_tag = 1'b0;
    logic rd_d   = 1'b0;

    always @(posedge clk) rd_d <= rd_tag;

    task automatic popRead();
        rd_exp_t e;
        if (rd_q.size() == 0) begin
            reportFail("read_underflow");
        end else begin
            e = rd_q.pop_front();
            checkOutput(e.name, salida, e.val);
        end
    endtask

    always @(negedge clk) if (rd_d) popRead();

    task automatic readCheck(input logic sel, input logic [N-1:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.val  = exp;
        e.name = name;
        rd_q.push_back(e);
        reg_sel = sel;
        addr    = a;
        rd_tag  = 1'b1;
        tick();
        rd_tag  = 1'b0;
    endtask

    // ---------------- SPI bit scoreboard ----------------
    task automatic popBit();
        bit_exp_t b;
        if (spi_q.size() == 0) begin
            reportFail("spi_unexpected_sclk");
        end else begin
            b = spi_q.pop_front();
            checkOutput("spi_mosi_cs", 32'({spi_mosi, spi_cs_n}), 32'({b.mosi, b.cs}));
        end
    endtask

    always @(posedge spi_sclk) popBit();

    task automatic pushFrame(input logic [DW-1:0] word, input logic [CS_N-1:0] cs);
        bit_exp_t b;
        for (int i = DW - 1; i >= 0; i--) begin
            b.mosi = word[i];
            b.cs   = cs;
            spi_q.push_back(b);
        end
    endtask

    // ---------------- burst scoreboard ----------------
    int              busy_cnt = 0;
    int              done_cnt = 0;
    int              cs_bad   = 0;
    logic [CS_N-1:0] cs_first = '1;

    task automatic checkBurstEnd(input int len, input int dcnt, input logic [CS_N-1:0] csf, input int bad);
        burst_exp_t e;
        if (burst_q.size() == 0) begin
            reportFail("burst_unexpected");
        end else begin
            e = burst_q.pop_front();
            checkOutput("burst_busy_cycles", 32'(len), 32'(e.len));
            checkOutput("burst_cs_n", 32'(csf), 32'(e.cs));
            checkOutput("burst_cs_glitches", 32'(bad), 32'd0);
            checkOutput("burst_done_pulses", 32'(dcnt), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt <= 0;
            done_cnt <= 0;
            cs_bad   <= 0;
        end else if (busy) begin
            if (busy_cnt == 0) cs_first <= spi_cs_n;
            else if (spi_cs_n !== cs_first) cs_bad <= cs_bad + 1;
            busy_cnt <= busy_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end else begin
            if (done) reportFail("done_outside_burst");
            if (busy_cnt != 0) begin
                checkBurstEnd(busy_cnt, done_cnt, cs_first, cs_bad);
                busy_cnt <= 0;
                done_cnt <= 0;
                cs_bad   <= 0;
            end
        end
    end

    task automatic startBurst(input logic [31:0] ctrl, input int frames, input logic [CS_N-1:0] cs);
        burst_exp_t e;
        e.len = frames * FRAME_CYC + 1;
        e.cs  = cs;
        burst_q.push_back(e);
        applyStimulus(1'b0, '0, ctrl);
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        if (busy) reportFail({name, "_timeout"});
        tick();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst     = 1'b0;
        wr      = 1'b0;
        reg_sel = 1'b0;
        addr    = '0;
        din     = '0;
        repeat (3) tick();

        checkOutput("rst_salida", salida, 32'd0);
        checkOutput("rst_sclk", 32'(spi_sclk), 32'd0);
        checkOutput("rst_mosi", 32'(spi_mosi), 32'd0);
        checkOutput("rst_cs_n", 32'(spi_cs_n), 32'hF);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();

        $display("[TB] single frame, MISO looped to MOSI");
        loop_miso = 1'b1;
        applyStimulus(1'b1, 5'd0, 32'h0000_00A5);
        pushFrame(8'hA5, 4'b1101);
        startBurst(ctrlWord(1, 0, 0, 0, 4'd1, 5'd0), 1, 4'b1101);
        checkOutput("busy_after_send", 32'(busy), 32'd1);
        waitIdle("t1");
        checkOutput("t1_cs_released", 32'(spi_cs_n), 32'hF);
        readCheck(1'b0, 5'd0, 32'h0001_0010, "t1_ctrl");
        readCheck(1'b1, 5'd0, 32'h0000_00A5, "t1_buf0");
        loop_miso = 1'b0;

        $display("[TB] four-frame burst, MISO tied low");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i + 1));
            pushFrame(8'(i + 1), 4'b1110);
        end
        startBurst(ctrlWord(1, 0, 0, 0, 4'd0, 5'd3), 4, 4'b1110);
        waitIdle("t2");
        for (int i = 0; i < 4; i++) readCheck(1'b1, 5'(i), 32'd0, "t2_buf_rx");
        readCheck(1'b0, 5'd0, 32'h0004_0300, "t2_ctrl");

        $display("[TB] all_1s / all_0s overrides");
        applyStimulus(1'b1, 5'd0, 32'h0000_0000);
        pushFrame(8'hFF, 4'b1011);
        startBurst(ctrlWord(1, 0, 1, 0, 4'd2, 5'd0), 1, 4'b1011);
        waitIdle("t3a");
        pushFrame(8'hFF, 4'b1011);
        startBurst(ctrlWord(1, 0, 1, 1, 4'd2, 5'd0), 1, 4'b1011);
        waitIdle("t3b");
        applyStimulus(1'b1, 5'd0, 32'h0000_00FF);
        pushFrame(8'h00, 4'b1011);
        startBurst(ctrlWord(1, 0, 0, 1, 4'd2, 5'd0), 1, 4'b1011);
        waitIdle("t3c");

        $display("[TB] out-of-range chip select");
        pushFrame(8'hFF, 4'b1111);
        startBurst(ctrlWord(1, 0, 1, 0, 4'd5, 5'd0), 1, 4'b1111);
        waitIdle("t3d");
        readCheck(1'b1, 5'd0, 32'd0, "t3d_buf0");

        $display("[TB] held chip select");
        applyStimulus(1'b1, 5'd0, 32'h0000_003C);
        pushFrame(8'h3C, 4'b0111);
        startBurst(ctrlWord(1, 1, 0, 0, 4'd3, 5'd0), 1, 4'b0111);
        waitIdle("t4");
        repeat (3) tick();
        checkOutput("t4_cs_held", 32'(spi_cs_n), 32'h7);
        applyStimulus(1'b0, 5'd0, ctrlWord(0, 0, 0, 0, 4'd3, 5'd0));
        checkOutput("t4_cs_release", 32'(spi_cs_n), 32'hF);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 5'd0, 32'h0000_00C3);
        pushFrame(8'hC3, 4'b1110);
        applyStimulus(1'b0, 5'd0, ctrlWord(1, 0, 0, 0, 4'd0, 5'd0));
        repeat (13) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        spi_q.delete();
        checkOutput("t5_cs_n", 32'(spi_cs_n), 32'hF);
        checkOutput("t5_sclk", 32'(spi_sclk), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_salida", salida, 32'd0);
        readCheck(1'b0, 5'd0, 32'd0, "t5_ctrl");
        pushFrame(8'hC3, 4'b1110);
        startBurst(ctrlWord(1, 0, 0, 0, 4'd0, 5'd0), 1, 4'b1110);
        waitIdle("t5");
        readCheck(1'b1, 5'd0, 32'd0, "t5_buf0");

        $display("[TB] writes during busy, then full-depth burst");
        applyStimulus(1'b1, 5'd5, 32'h0000_005A);
        applyStimulus(1'b1, 5'd0, 32'h0000_0081);
        pushFrame(8'h81, 4'b1110);
        startBurst(ctrlWord(1, 0, 0, 0, 4'd0, 5'd0), 1, 4'b1110);
        repeat (5) tick();
        applyStimulus(1'b0, 5'd0, ctrlWord(1, 0, 0, 0, 4'd0, 5'd7));
        applyStimulus(1'b1, 5'd5, 32'h0000_00FF);
        waitIdle("t6a");
        readCheck(1'b1, 5'd5, 32'h0000_005A, "t6_buf5_kept");
        readCheck(1'b0, 5'd0, 32'h0001_0000, "t6_ctrl_kept");
        for (int i = 0; i < 32; i++) pushFrame(8'h00, 4'b1110);
        startBurst(ctrlWord(1, 0, 0, 1, 4'd0, 5'd31), 32, 4'b1110);
        waitIdle("t6b");
        readCheck(1'b0, 5'd0, 32'h0020_1F08, "t6_ctrl_nrx32");
        readCheck(1'b1, 5'd5, 32'd0, "t6_buf5_rx");

        repeat (4) tick();
        checkOutput("spi_queue_drained", 32'(spi_q.size()), 32'd0);
        checkOutput("burst_queue_drained", 32'(burst_q.size()), 32'd0);
        checkOutput("read_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
